pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage: holds the instruction address, advances it by one per cycle, and redirects on branch, call and return. Adds a hardware return-address stack (RAS) for subroutine call/return, a configurable reset vector and sticky stack-error flags. Sits between the hazard/branch logic and instruction memory, replacing the fixed 10-bit PC and its separate adder.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_ras.sv | 62 ++++++
 rtl/pc_unit.sv | 112 +++++++++++
 tb/tb_pc_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter and its return-address stack.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_INC,
        PC_HOLD,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_sel_t;

    // Width needed to count 0..depth entries inclusive.
    function automatic int ras_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, and an empty pop is a no-op.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [ADDR_W-1:0]                    push_data,
    output logic [ADDR_W-1:0]                    top,
    output logic [ras_count_w(RAS_DEPTH)-1:0]    count,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = ras_count_w(RAS_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     wp_dec;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign wp_dec    = wp - PW'(1);
    assign top       = mem[wp_dec];
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign do_pop    = pop && !empty;
    assign do_push   = push && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            count <= '0;
        end else if (do_pop) begin
            wp    <= wp_dec;
            count <= count - CW'(1);
        end else if (do_push) begin
            // A push onto a full stack overwrites the oldest slot, so the count saturates.
            wp <= wp + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority redirect decode, PC register, RAS and sticky stack-error flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              branch,
    input  logic                              call,
    input  logic                              ret,
    input  logic [ADDR_W-1:0]                 target,
    input  logic                              clr_err,
    output logic [ADDR_W-1:0]                 instr_address,
    output logic [ras_count_w(RAS_DEPTH)-1:0] ras_count,
    output logic                              ras_empty,
    output logic                              ras_full,
    output logic                              err_overflow,
    output logic                              err_underflow
);

    localparam int CW = ras_count_w(RAS_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push;
    logic              ras_pop;
    logic              set_ovf;
    logic              set_unf;

    always_comb begin
        sel = PC_INC;
        if (ret) begin
            sel = PC_RET;
        end else if (call) begin
            sel = PC_CALL;
        end else if (branch) begin
            sel = PC_BRANCH;
        end else if (stall) begin
            sel = PC_HOLD;
        end
    end

    assign pc_inc   = instr_address + ADDR_W'(1);
    assign ras_push = (sel == PC_CALL);
    assign ras_pop  = (sel == PC_RET);

    always_comb begin
        pc_next = pc_inc;
        case (sel)
            PC_INC:    pc_next = pc_inc;
            PC_HOLD:   pc_next = instr_address;
            PC_BRANCH: pc_next = target;
            PC_CALL:   pc_next = target;
            // An empty-stack return has nowhere to go, so the PC simply holds.
            PC_RET:    pc_next = ras_empty ? instr_address : ras_top;
            default:   pc_next = pc_inc;
        endcase
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (set_ovf),
        .underflow (set_unf)
    );

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == DEPTH_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_address <= RESET_VEC;
        end else begin
            instr_address <= pc_next;
        end
    end

    // A new error in the same cycle as clr_err wins, so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (set_ovf) begin
                err_overflow <= 1'b1;
            end else if (clr_err) begin
                err_overflow <= 1'b0;
            end
            if (set_unf) begin
                err_underflow <= 1'b1;
            end else if (clr_err) begin
                err_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with RESET_VEC=0x3F0, ADDR_W=10 and RAS_DEPTH=4.
module tb_pc_unit;

    localparam int ADDR_W = 10;
    localparam int RAS_DEPTH = 4;
    localparam logic [ADDR_W-1:0] RVEC = 10'h3F0;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              branch;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic              clr_err;
    logic [ADDR_W-1:0] instr_address;
    logic [2:0]        ras_count;
    logic              ras_empty;
    logic              ras_full;
    logic              err_overflow;
    logic              err_underflow;

    int total;
    int bad;

    pc_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RVEC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .clr_err       (clr_err),
        .instr_address (instr_address),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch = 0; call = 0; ret = 0; clr_err = 0;
    endtask

    task automatic chk_state(input string tag, input logic [9:0] pc, input logic [2:0] cnt,
                             input logic ovf, input logic unf);
        chk({tag, "_pc"}, 32'(instr_address), 32'(pc));
        chk({tag, "_cnt"}, 32'(ras_count), 32'(cnt));
        chk({tag, "_empty"}, 32'(ras_empty), 32'(cnt == 3'd0));
        chk({tag, "_full"}, 32'(ras_full), 32'(cnt == 3'd4));
        chk({tag, "_ovf"}, 32'(err_overflow), 32'(ovf));
        chk({tag, "_unf"}, 32'(err_underflow), 32'(unf));
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 0;
        target = '0;
        idle();

        // Reset held over two edges, then released between edges.
        step();
        step();
        chk_state("reset", 10'h3F0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1;
        #1;

        // Free-run across the 10-bit wrap.
        for (int i = 0; i < 20; i++) begin
            chk("freerun_pc", 32'(instr_address), 32'((10'h3F0 + 10'(i)) & 10'h3FF));
            step();
        end
        chk("freerun_end", 32'(instr_address), 32'h004);

        // Stall window with a branch on its second cycle.
        branch = 1; target = 10'h010;
        step();
        chk("br_to_010", 32'(instr_address), 32'h010);
        idle(); stall = 1;
        step();
        chk("stall1", 32'(instr_address), 32'h010);
        branch = 1; target = 10'h100;
        step();
        chk("stall2_branch", 32'(instr_address), 32'h100);
        branch = 0;
        step();
        chk("stall3", 32'(instr_address), 32'h100);
        stall = 0;
        step();
        chk("stall_release", 32'(instr_address), 32'h101);

        // Nested call/return.
        branch = 1; target = 10'h020;
        step();
        idle();
        chk("br_to_020", 32'(instr_address), 32'h020);
        call = 1; target = 10'h200;
        step();
        chk_state("call1", 10'h200, 3'd1, 1'b0, 1'b0);
        call = 0;
        step();
        chk("after_call1", 32'(instr_address), 32'h201);
        call = 1; target = 10'h300;
        step();
        chk_state("call2", 10'h300, 3'd2, 1'b0, 1'b0);
        idle(); ret = 1;
        step();
        chk_state("ret1", 10'h202, 3'd1, 1'b0, 1'b0);
        step();
        chk_state("ret2", 10'h021, 3'd0, 1'b0, 1'b0);

        // Five calls into a 4-deep stack: return address 0x022 is lost.
        idle(); call = 1;
        target = 10'h040; step(); chk_state("c5_1", 10'h040, 3'd1, 1'b0, 1'b0);
        target = 10'h050; step(); chk_state("c5_2", 10'h050, 3'd2, 1'b0, 1'b0);
        target = 10'h060; step(); chk_state("c5_3", 10'h060, 3'd3, 1'b0, 1'b0);
        target = 10'h070; step(); chk_state("c5_4", 10'h070, 3'd4, 1'b0, 1'b0);
        target = 10'h080; step(); chk_state("c5_5", 10'h080, 3'd4, 1'b1, 1'b0);
        idle(); ret = 1;
        step(); chk_state("r4_1", 10'h071, 3'd3, 1'b1, 1'b0);
        step(); chk_state("r4_2", 10'h061, 3'd2, 1'b1, 1'b0);
        step(); chk_state("r4_3", 10'h051, 3'd1, 1'b1, 1'b0);
        step(); chk_state("r4_4", 10'h041, 3'd0, 1'b1, 1'b0);

        // Underflow holds the PC; clr_err clears, but a same-cycle error wins.
        step(); chk_state("unf", 10'h041, 3'd0, 1'b1, 1'b1);
        idle(); clr_err = 1;
        step(); chk_state("clr", 10'h042, 3'd0, 1'b0, 1'b0);
        ret = 1;
        step(); chk_state("unf_and_clr", 10'h042, 3'd0, 1'b0, 1'b1);
        idle(); clr_err = 1;
        step(); chk_state("clr2", 10'h043, 3'd0, 1'b0, 1'b0);

        // Call beats branch; ret beats call.
        idle(); call = 1; branch = 1; target = 10'h100;
        step(); chk_state("call_over_br", 10'h100, 3'd1, 1'b0, 1'b0);
        idle(); call = 1; ret = 1; target = 10'h200;
        step(); chk_state("ret_over_call", 10'h044, 3'd0, 1'b0, 1'b0);
        step(); chk_state("ret_over_call_unf", 10'h044, 3'd0, 1'b0, 1'b1);
        idle(); call = 1; target = 10'h155;
        step(); chk_state("pre_reset", 10'h155, 3'd1, 1'b0, 1'b1);

        // Asynchronous reset in mid-cycle with a call still requested.
        #3;
        reset = 0;
        #1;
        chk_state("async_reset", 10'h3F0, 3'd0, 1'b0, 1'b0);
        step();
        chk_state("reset_hold", 10'h3F0, 3'd0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        reset = 1;
        step();
        chk_state("post_reset", 10'h3F1, 3'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
